counter_extender: RTL

- Downstream consumer of the 4-bit wrap counter's `counter[3:0]` and `overflow` outputs.
- Extends the count with an upper word to form a wide composite count.
- Checks the upstream count sequence and flags sticky errors.
- Signals a programmable terminal value, and queues one upper-word snapshot per overflow in a small valid/ready event FIFO for a monitor or CPU-side reader.

---
 rtl/counter_ext_pkg.sv | 13 +
 rtl/counter_extender_if.sv | 31 +++
 rtl/ovf_event_fifo.sv | 59 +++++
 rtl/counter_extender.sv | 104 ++++++++++
 4 files changed

// File: rtl/counter_ext_pkg.sv
// Shared definitions for the counter extender: lower-word geometry and FSM states.
package counter_ext_pkg;

   localparam int                 LOWER_W    = 4;
   localparam logic [LOWER_W-1:0] LOWER_TERM = 4'hF;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/counter_extender_if.sv
// Bus between the upstream counter / event reader and the counter extender.
interface counter_extender_if
   import counter_ext_pkg::*;
#(
   parameter int UPPER_W = 12
) ();

   logic [LOWER_W-1:0]         counter;
   logic                       overflow;
   logic                       clear;
   logic [UPPER_W-1:0]         term_upper;
   logic [UPPER_W+LOWER_W-1:0] count_full;
   logic                       term_hit;
   logic                       ev_valid;
   logic                       ev_ready;
   logic [UPPER_W-1:0]         ev_data;
   logic                       ev_drop;
   logic                       seq_err;
   logic                       halted;

   modport master (
      output counter, overflow, clear, term_upper, ev_ready,
      input  count_full, term_hit, ev_valid, ev_data, ev_drop, seq_err, halted
   );

   modport slave (
      input  counter, overflow, clear, term_upper, ev_ready,
      output count_full, term_hit, ev_valid, ev_data, ev_drop, seq_err, halted
   );

endinterface

// File: rtl/ovf_event_fifo.sv
// Small circular FIFO of upper-word snapshots with a sticky drop flag.
module ovf_event_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_drop;
   logic             w_full;
   logic             w_pop;
   logic             w_push_ok;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_pop     = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push_ok = i_push && (!w_full || w_pop);
   assign o_data    = r_mem[r_rd_ptr];
   assign o_drop    = r_drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_drop   <= 1'b0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_drop   <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
         if (i_push && !w_push_ok) r_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok && !i_clear) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/counter_extender.sv
// Extends a 4-bit wrap counter with an upper word, checks its sequence and
// queues one upper-word snapshot per overflow.
module counter_extender
   import counter_ext_pkg::*;
#(
   parameter int UPPER_W      = 12,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_AT_TERM = 0
) (
   input logic               clk,
   input logic               reset,
   counter_extender_if.slave bus
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [LOWER_W-1:0] r_counter_q;
   logic               r_ovf_q;
   logic [UPPER_W-1:0] r_upper_q;
   logic [UPPER_W-1:0] w_upper_inc;
   logic               r_term_hit;
   logic               r_seq_err;
   logic               w_inc;
   logic               w_hit;
   logic               w_seq_bad;
   logic               w_fifo_empty;

   assign w_upper_inc = r_upper_q + UPPER_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_SYNC;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_inc       = 1'b0;
      w_hit       = 1'b0;
      w_seq_bad   = 1'b0;
      unique case (r_state)
         ST_SYNC: w_state_nxt = ST_RUN;
         ST_RUN: begin
            w_seq_bad = (bus.overflow != (bus.counter == LOWER_TERM)) ||
                        (bus.counter != (r_counter_q + LOWER_W'(1)));
            w_inc     = r_ovf_q;
            w_hit     = r_ovf_q && (w_upper_inc == bus.term_upper);
            if ((STOP_AT_TERM != 0) && w_hit) w_state_nxt = ST_HALT;
         end
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_SYNC;
      endcase
      if (bus.clear) begin
         w_state_nxt = ST_SYNC;
         w_inc       = 1'b0;
         w_hit       = 1'b0;
         w_seq_bad   = 1'b0;
      end
   end

   // The upper word steps on the same edge that brings counter_q from F to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_counter_q <= '0;
         r_ovf_q     <= 1'b0;
         r_upper_q   <= '0;
         r_term_hit  <= 1'b0;
         r_seq_err   <= 1'b0;
      end else begin
         r_counter_q <= bus.counter;
         r_ovf_q     <= (r_state == ST_SYNC) ? 1'b0 : bus.overflow;
         if (bus.clear) begin
            r_upper_q  <= '0;
            r_term_hit <= 1'b0;
            r_seq_err  <= 1'b0;
         end else begin
            r_term_hit <= w_hit;
            if (w_inc)     r_upper_q <= w_upper_inc;
            if (w_seq_bad) r_seq_err <= 1'b1;
         end
      end
   end

   ovf_event_fifo #(
      .WIDTH (UPPER_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clear (bus.clear),
      .i_push  (w_inc),
      .i_data  (w_upper_inc),
      .i_pop   (bus.ev_ready),
      .o_data  (bus.ev_data),
      .o_empty (w_fifo_empty),
      .o_drop  (bus.ev_drop)
   );

   assign bus.count_full = {r_upper_q, r_counter_q};
   assign bus.term_hit   = r_term_hit;
   assign bus.ev_valid   = !w_fifo_empty;
   assign bus.seq_err    = r_seq_err;
   assign bus.halted     = (r_state == ST_HALT);

endmodule
